cipher_cfg_loader: RTL and testbench
====================================

// Module: cipher_cfg_loader
// PURPOSE
//  Upstream config feeder for the dual XOR stream cipher. Accepts the cipher's
//  (4*M+2)-bit configuration frame as bytes over a valid/ready host port.
//  Once the whole frame is buffered, drives cfg_en/cfg_i for exactly 4*M+2
//  contiguous cycles, so the cipher's ld counter fires on the last bit.
//  Captures the cipher's previous configuration from cfg_o as readback.
// PARAMETERS
//  M         32   LFSR width of the cipher; frame CFG_BITS = 4*M+2 (130 at M=32)
//  localparam CFG_BITS = 4*M+2; NBYTES = (CFG_BITS+7)/8 (17 at M=32)
// PORTS
//  clk       in   1         clock
//  rst       in   1         synchronous, active-high reset
//  in_valid  in   1         host byte valid
//  in_ready  out  1         loader can accept a byte
//  in_data   in   8         host byte; byte0 = frame bits [7:0], LSB-first
//  cfg_en    out  1         to cipher cfg_en; high only during SHIFT
//  cfg_i     out  1         to cipher cfg_i; serial frame bit
//  cfg_o     in   1         from cipher cfg_o; old config bit during shift
//  busy      out  1         high in SHIFT and DONE
//  done      out  1         1-cycle pulse after the last bit is shifted
//  rb_word   out  CFG_BITS  readback: cipher config as it was before the load
// BEHAVIOUR
//  Reset: state=COLLECT, byte_cnt=0, bit_cnt=0, in_ready=1, cfg_en=0, cfg_i=0,
//   busy=0, done=0, rb_word=0, frame buffer=0. Reset mid-SHIFT: cfg_en=0 on the
//   next edge. The cipher sees a short frame; the host must also reset the cipher.
//  FSM COLLECT -> SHIFT -> DONE -> COLLECT.
//  COLLECT: in_ready=1. A byte transfers on in_valid&in_ready at the clock edge.
//   Byte n goes to buf[8n+7:8n], then byte_cnt++. The handshake on byte
//   NBYTES-1 sets byte_cnt=0 and moves to SHIFT on the next cycle.
//   Bits of the last byte above CFG_BITS-1 (bits [7:2] at M=32) are discarded.
//  SHIFT: in_ready=0, cfg_en=1 (registered), cfg_i=buf[0]. Each cycle buf
//   shifts right by 1 and bit_cnt++. cfg_en stays high for exactly CFG_BITS
//   cycles, with no gaps. Bit k of the frame is on cfg_i in SHIFT cycle k.
//   In the same cycle cfg_o is sampled into rb shift reg bit k (LSB-first).
//   When bit_cnt==CFG_BITS-1: next state is DONE, bit_cnt=0.
//  DONE: one cycle. cfg_en=0, cfg_i=0, done=1, rb_word updated, in_ready=0.
//   Next cycle returns to COLLECT.
//  rb_word holds its value until the next DONE or rst. It is not updated in SHIFT.
//  Latency: last-byte handshake at edge t; cfg_en high for cycles t+1..t+CFG_BITS;
//   done high in cycle t+CFG_BITS+1; in_ready high again at t+CFG_BITS+2.
//  After the load, the cipher's cfg_reg bit k equals frame bit k: bit 4M+1 =
//   a_mux, bit 4M = d_en, then tx taps, tx state, rx taps, rx state.
//  in_valid while in_ready=0: ignored, no data lost. The host holds the byte
//   until ready (AXI-style: in_data is stable while in_valid=1).
//  Partial frame: byte_cnt persists indefinitely. There is no timeout.
//   Only rst clears a partial frame.
//  cfg_i is 0 whenever cfg_en=0.
//  in_ready is registered and depends only on state.
// TESTING
//  T1 rst then 17 bytes: a_mux=1, d_en=1, tx/rx taps 0x48000000, states 0x55
//   -> cfg_en high for 130 cycles, one done pulse; cipher ld pulses once,
//   a_mux=1, d_en=1.
//  T2 two back-to-back loads, frame A then frame B -> second rb_word == frame A;
//   the first rb_word equals the cipher reset default.
//  T3 in_valid toggled randomly, with 3-cycle gaps between bytes -> frame
//   assembled byte-exact; cfg_en never starts before byte 17.
//  T4 in_valid held high through SHIFT/DONE -> in_ready=0, no byte consumed;
//   the next frame's byte0 is accepted in the first COLLECT cycle.
//  T5 rst asserted at SHIFT cycle 60 -> cfg_en=0 next cycle, byte_cnt=0,
//   rb_word=0, no done pulse.
//  T6 last byte = 0xFF -> bits above 129 discarded; cfg_i toggles for exactly
//   130 cycles; cipher a_mux and d_en are taken from bits 129/128.

Source files
------------

// File: rtl/cipher_cfg_loader.sv
// cipher_cfg_loader
//
// Feeds the dual XOR stream cipher its (4*M+2)-bit configuration frame.
// The host delivers the frame as bytes over a valid/ready port (byte 0 holds
// frame bits [7:0], LSB-first). Once the whole frame is buffered, the loader
// drives cfg_en/cfg_i for exactly CFG_BITS contiguous cycles, one frame bit
// per cycle. This lets the cipher's load counter fire on the last bit. While
// shifting, it captures the cipher's outgoing configuration from cfg_o and
// presents it as rb_word.
//
// Ports
//   clk       clock
//   rst       synchronous, active-high reset
//   in_valid  host byte valid
//   in_ready  loader can accept a byte (registered, depends only on state)
//   in_data   host byte
//   cfg_en    cipher config enable, high only while shifting
//   cfg_i     serial frame bit to the cipher, 0 whenever cfg_en is 0
//   cfg_o     serial old-config bit from the cipher
//   busy      high while shifting and in the done cycle
//   done      one-cycle pulse after the last bit has been shifted
//   rb_word   cipher configuration as it was before the most recent load

module cipher_cfg_loader #(
    parameter int M = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_data,
    output logic            cfg_en,
    output logic            cfg_i,
    input  logic            cfg_o,
    output logic            busy,
    output logic            done,
    output logic [4*M+1:0]  rb_word
);

    localparam int CFG_BITS   = 4 * M + 2;
    localparam int NBYTES     = (CFG_BITS + 7) / 8;
    localparam int BUF_W      = NBYTES * 8;
    localparam int BCW        = $clog2(NBYTES);
    localparam int BITW       = $clog2(CFG_BITS);
    localparam int LAST_VALID = CFG_BITS - 8 * (NBYTES - 1);

    // Only the low LAST_VALID bits of the final byte belong to the frame.
    localparam logic [7:0]      LAST_MASK = 8'((1 << LAST_VALID) - 1);
    localparam logic [BCW-1:0]  LAST_BYTE = BCW'(NBYTES - 1);
    localparam logic [BITW-1:0] LAST_BIT  = BITW'(CFG_BITS - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SHIFT   = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [BCW-1:0]      byte_cnt;
    logic [BITW-1:0]     bit_cnt;
    logic [BUF_W-1:0]    frame_buf;
    logic [CFG_BITS-2:0] rb_shift;
    logic [CFG_BITS-1:0] rb_next;
    logic [BCW+2:0]      byte_base;
    logic [7:0]          byte_in;
    logic                take;
    logic                last_byte;
    logic                last_bit;

    assign take      = in_valid && (state == COLLECT);
    assign last_byte = (byte_cnt == LAST_BYTE);
    assign last_bit  = (bit_cnt == LAST_BIT);
    assign byte_base = {byte_cnt, 3'b000};
    assign byte_in   = last_byte ? (in_data & LAST_MASK) : in_data;

    // The newest cfg_o sample enters at the top. After CFG_BITS shifts, the
    // sample taken in shift cycle k sits at bit k.
    assign rb_next = {cfg_o, rb_shift};

    // The frame buffer always shifts toward bit 0, so the current frame bit
    // is frame_buf[0]. Gating with cfg_en keeps cfg_i at 0 outside SHIFT.
    assign cfg_i = cfg_en & frame_buf[0];

    always_comb begin
        next_state = state;
        case (state)
            COLLECT: if (take && last_byte) next_state = SHIFT;
            SHIFT:   if (last_bit)          next_state = DONE;
            DONE:                           next_state = COLLECT;
            default:                        next_state = COLLECT;
        endcase
    end

    // The handshake and cipher outputs are registered from next_state, so
    // they line up with the state they describe without any decode glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            in_ready  <= 1'b1;
            cfg_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            byte_cnt  <= '0;
            bit_cnt   <= '0;
            frame_buf <= '0;
            rb_shift  <= '0;
            rb_word   <= '0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state == COLLECT);
            cfg_en   <= (next_state == SHIFT);
            busy     <= (next_state != COLLECT);
            done     <= (next_state == DONE);

            if (take) begin
                frame_buf[byte_base +: 8] <= byte_in;
                byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
            end

            // The readback word is published on the edge that ends the last
            // shift cycle, so it is already valid while done is high.
            if (state == SHIFT) begin
                frame_buf <= frame_buf >> 1;
                rb_shift  <= rb_next[CFG_BITS-1:1];
                if (last_bit) begin
                    bit_cnt <= '0;
                    rb_word <= rb_next;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cipher_cfg_loader.sv
// tb_cipher_cfg_loader
//
// Directed and randomized bench for cipher_cfg_loader. The cipher side is a
// small behavioural model: a CFG_BITS-wide config register that shifts cfg_i
// in at the top on every cfg_en cycle and exposes its bit 0 on cfg_o, plus a
// load counter. Expected values come from the frame being sent and from the
// previous frame that the cipher held.

module tb_cipher_cfg_loader;

    localparam int M          = 32;
    localparam int CFG_BITS   = 4 * M + 2;
    localparam int NBYTES     = (CFG_BITS + 7) / 8;
    localparam int LAST_VALID = CFG_BITS - 8 * (NBYTES - 1);

    typedef logic [CFG_BITS-1:0] word_t;

    localparam word_t CIPHER_DEFAULT = {2'b01, 32'hA5A5_0F0F, 32'h0000_0001,
                                        32'h8000_0003, 32'hDEAD_BEEF};

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       cfg_en;
    logic       cfg_i;
    logic       cfg_o;
    logic       busy;
    logic       done;
    word_t      rb_word;

    int n_checks = 0;
    int n_fail   = 0;

    cipher_cfg_loader #(.M(M)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .cfg_en   (cfg_en),
        .cfg_i    (cfg_i),
        .cfg_o    (cfg_o),
        .busy     (busy),
        .done     (done),
        .rb_word  (rb_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural cipher config chain and load counter.
    logic  cipher_rst;
    word_t cipher_cfg;
    int    ld_cnt    = 0;
    int    ld_pulses = 0;

    assign cfg_o = cipher_cfg[0];

    always @(posedge clk) begin
        if (cipher_rst) begin
            cipher_cfg <= CIPHER_DEFAULT;
            ld_cnt     <= 0;
        end else if (cfg_en) begin
            cipher_cfg <= {cfg_i, cipher_cfg[CFG_BITS-1:1]};
            if (ld_cnt == CFG_BITS - 1) begin
                ld_cnt    <= 0;
                ld_pulses <= ld_pulses + 1;
            end else begin
                ld_cnt <= ld_cnt + 1;
            end
        end
    end

    // Passive monitor sampled mid-cycle. Its counters only ever grow; the
    // directed steps take differences against snapshots.
    int   mon_en_cycles = 0;
    int   mon_en_starts = 0;
    int   mon_done      = 0;
    int   mon_glitch    = 0;
    logic mon_prev_en   = 1'b0;
    bit   mon_bits[$];

    always @(negedge clk) begin
        if (cfg_en === 1'b1) begin
            mon_bits.push_back(cfg_i);
            mon_en_cycles++;
            if (mon_prev_en !== 1'b1) mon_en_starts++;
        end else if (cfg_i !== 1'b0) begin
            mon_glitch++;
        end
        if (done === 1'b1) mon_done++;
        mon_prev_en = cfg_en;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input word_t observed, input word_t expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic word_t randFrame();
        word_t f;
        for (int i = 0; i < CFG_BITS; i++) f[i] = 1'($urandom_range(1, 0));
        return f;
    endfunction

    // Offers one byte after 'gap' idle cycles and holds it until accepted.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        bit acc;
        int waits;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        acc   = 1'b0;
        waits = 0;
        while (!acc && waits < 500) begin
            acc = in_ready;
            @(posedge clk);
            if (!acc) begin
                waits++;
                @(negedge clk);
            end
        end
        checkOutput("byte_accept", word_t'(acc), word_t'(1));
    endtask

    // Sends a whole frame, follows it through SHIFT and DONE, and checks the
    // serial stream, timing, readback and the cipher model contents.
    task automatic runLoad(input word_t frame, input logic [7:0] top_junk, input int gap_kind,
                           input bit skip_first, input bit hold, input logic [7:0] next_b0,
                           input word_t exp_rb, input string tag);
        logic [NBYTES*8-1:0] ext;
        int    gap, en0, s0, d0, q0, ld0, k, done_k, ready_bad;
        logic  ready_after;
        word_t serial;

        ext = '0;
        ext[CFG_BITS-1:0] = frame;
        ext[NBYTES*8-1:CFG_BITS] = top_junk[7:LAST_VALID];
        en0 = mon_en_cycles;
        s0  = mon_en_starts;
        d0  = mon_done;
        q0  = mon_bits.size();
        ld0 = ld_pulses;

        for (int n = (skip_first ? 1 : 0); n < NBYTES; n++) begin
            gap = (gap_kind == 2) ? 3 : (gap_kind == 1) ? int'($urandom_range(3, 0)) : 0;
            applyStimulus(ext[8*n +: 8], gap);
        end
        checkOutput({tag, "_no_early_shift"}, word_t'(mon_en_cycles), word_t'(en0));

        k = 0;
        done_k = 0;
        ready_bad = 0;
        ready_after = 1'b0;
        while (k < 400) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                in_valid = hold;
                in_data  = hold ? next_b0 : 8'($urandom);
            end
            if (done_k == 0 && in_ready !== 1'b0) ready_bad++;
            if (done_k == 0 && done === 1'b1) done_k = k;
            if (done_k != 0 && k == done_k + 1) begin
                ready_after = in_ready;
                break;
            end
        end

        serial = 'x;
        for (int i = 0; i < CFG_BITS; i++)
            if (q0 + i < mon_bits.size()) serial[i] = mon_bits[q0 + i];

        checkOutput({tag, "_done_latency"}, word_t'(done_k), word_t'(CFG_BITS + 1));
        checkOutput({tag, "_ready_return"}, word_t'(ready_after), word_t'(1));
        checkOutput({tag, "_ready_low"},    word_t'(ready_bad), word_t'(0));
        checkOutput({tag, "_en_cycles"},    word_t'(mon_en_cycles - en0), word_t'(CFG_BITS));
        checkOutput({tag, "_en_bursts"},    word_t'(mon_en_starts - s0), word_t'(1));
        checkOutput({tag, "_done_pulses"},  word_t'(mon_done - d0), word_t'(1));
        checkOutput({tag, "_serial"},       serial, frame);
        checkOutput({tag, "_rb_word"},      rb_word, exp_rb);
        checkOutput({tag, "_cipher_cfg"},   cipher_cfg, frame);
        checkOutput({tag, "_ld_pulses"},    word_t'(ld_pulses - ld0), word_t'(1));
        @(posedge clk);
    endtask

    // Sends a frame, then resets loader and cipher in shift cycle 60.
    task automatic resetMidShift(input word_t frame);
        int en0, d0;
        en0 = mon_en_cycles;
        d0  = mon_done;
        for (int n = 0; n < NBYTES; n++) applyStimulus(frame[8*n +: 8], 0);
        for (int k = 1; k <= 61; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
        end
        rst        = 1'b1;
        cipher_rst = 1'b1;
        @(negedge clk);
        checkOutput("t5_cfg_en_off", word_t'(cfg_en), word_t'(0));
        checkOutput("t5_in_ready",   word_t'(in_ready), word_t'(1));
        checkOutput("t5_busy",       word_t'(busy), word_t'(0));
        checkOutput("t5_rb_cleared", rb_word, word_t'(0));
        rst        = 1'b0;
        cipher_rst = 1'b0;
        repeat (140) @(negedge clk);
        checkOutput("t5_no_done",    word_t'(mon_done - d0), word_t'(0));
        checkOutput("t5_en_cycles",  word_t'(mon_en_cycles - en0), word_t'(61));
        checkOutput("t5_rb_held",    rb_word, word_t'(0));
    endtask

    initial begin
        word_t prev, f1, fa, fb, fc, fd, fe, ff, f6;

        rst        = 1'b1;
        cipher_rst = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", word_t'(in_ready), word_t'(1));
        checkOutput("reset_cfg_en",   word_t'(cfg_en), word_t'(0));
        checkOutput("reset_cfg_i",    word_t'(cfg_i), word_t'(0));
        checkOutput("reset_busy",     word_t'(busy), word_t'(0));
        checkOutput("reset_done",     word_t'(done), word_t'(0));
        checkOutput("reset_rb_word",  rb_word, word_t'(0));
        rst        = 1'b0;
        cipher_rst = 1'b0;
        prev = CIPHER_DEFAULT;

        $display("[TB] T1 reference frame");
        f1 = {1'b1, 1'b1, 32'h4800_0000, 32'h0000_0055, 32'h4800_0000, 32'h0000_0055};
        runLoad(f1, 8'($urandom), 0, 1'b0, 1'b0, 8'h00, prev, "t1");
        checkOutput("t1_amux_den", word_t'(cipher_cfg[CFG_BITS-1 -: 2]), word_t'(2'b11));
        prev = f1;

        $display("[TB] T2 back-to-back loads");
        fa = randFrame();
        runLoad(fa, 8'($urandom), 0, 1'b0, 1'b0, 8'h00, prev, "t2a");
        prev = fa;
        fb = randFrame();
        runLoad(fb, 8'($urandom), 0, 1'b0, 1'b0, 8'h00, prev, "t2b");
        prev = fb;

        $display("[TB] T3 gapped byte delivery");
        fc = randFrame();
        runLoad(fc, 8'($urandom), 2, 1'b0, 1'b0, 8'h00, prev, "t3a");
        prev = fc;
        fd = randFrame();
        fe = randFrame();
        runLoad(fd, 8'($urandom), 1, 1'b0, 1'b1, fe[7:0], prev, "t3b");
        prev = fd;

        $display("[TB] T4 valid held through shift");
        runLoad(fe, 8'($urandom), 1, 1'b1, 1'b0, 8'h00, prev, "t4");
        checkOutput("t5_rb_before", rb_word, fd);

        $display("[TB] T5 reset during shift");
        ff = randFrame();
        resetMidShift(ff);
        prev = CIPHER_DEFAULT;

        $display("[TB] T6 last byte all ones");
        f6 = randFrame();
        f6[CFG_BITS-1 -: 2] = 2'b11;
        runLoad(f6, 8'hFF, 0, 1'b0, 1'b0, 8'h00, prev, "t6");
        checkOutput("t6_amux_den", word_t'(cipher_cfg[CFG_BITS-1 -: 2]), word_t'(2'b11));

        checkOutput("cfg_i_idle_zero", word_t'(mon_glitch), word_t'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
